// File: rtl/gamma_pkg.sv
// Shared definitions for the gamma cycle sequencer: FSM state encoding,
// the time-field width function and the NO_SPIKE (infinity) value.
package gamma_pkg;

    // Sequencer states; encoding is visible on the dbg_state output.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        COMPUTE = 2'd2,
        HOLD    = 2'd3
    } gamma_state_e;

    // One extra bit beyond the index range so the window length itself
    // (used as "no spike seen") fits in a time field.
    function automatic int calc_tw(input int gamma_cycle_width);
        return $clog2(gamma_cycle_width) + 1;
    endfunction

    // Time value reported for a channel that never fired in the window.
    function automatic int no_spike_value(input int gamma_cycle_width);
        return gamma_cycle_width;
    endfunction

endpackage

// File: rtl/first_spike_capture.sv
// One channel of first-spike capture: a TW-bit time register plus a
// "captured" flag. The first spike seen while enabled latches the current
// time; everything after that is ignored until the next load.
module first_spike_capture
    import gamma_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    localparam int TW = calc_tw(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          load_i,   // entering CLEAR: reload NO_SPIKE, drop flag
    input  logic          en_i,     // high only during COMPUTE
    input  logic          spike_i,
    input  logic [TW-1:0] time_i,
    output logic [TW-1:0] time_o
);

    localparam logic [TW-1:0] NO_SPIKE = TW'(no_spike_value(GAMMA_CYCLE_WIDTH));

    logic [TW-1:0] time_q, time_d;
    logic          flag_q, flag_d;

    // Next-state: load has priority, then a first spike in the window.
    always_comb begin
        time_d = time_q;
        flag_d = flag_q;
        if (load_i) begin
            time_d = NO_SPIKE;
            flag_d = 1'b0;
        end else if (en_i && spike_i && !flag_q) begin
            time_d = time_i;
            flag_d = 1'b1;
        end
    end

    // Capture registers, forced to NO_SPIKE / clear by reset.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            time_q <= NO_SPIKE;
            flag_q <= 1'b0;
        end else begin
            time_q <= time_d;
            flag_q <= flag_d;
        end
    end

    assign time_o = time_q;

endmodule

// File: rtl/gamma_cycle_sequencer.sv
// Gamma cycle sequencer: IDLE -> CLEAR (operator clear held RST_CYCLES)
// -> COMPUTE (GAMMA_CYCLE_WIDTH cycles, gamma_time 0..W-1, first-spike
// capture per channel) -> HOLD (results offered until res_ready).
// Handshake: res_valid is high only in HOLD and res_time is frozen there;
// the transfer happens on the aclk edge where res_valid and res_ready are
// both 1.
// Build option: define GAMMA_AUTO_RESTART_EN to go straight from a HOLD
// handshake back into CLEAR; otherwise the handshake returns to IDLE and
// a new start is needed.
module gamma_cycle_sequencer
    import gamma_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_CH            = 4,
    parameter int RST_CYCLES        = 2,
    localparam int TW = calc_tw(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 aclk,
    input  logic                 grst,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    spike_in,
    output logic                 op_rst,
    output logic [TW-1:0]        gamma_time,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NUM_CH*TW-1:0] res_time,
    output logic [1:0]           dbg_state
);

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] GT_LAST  = TW'(GAMMA_CYCLE_WIDTH - 1);

    gamma_state_e  state_q;
    logic [CW-1:0] clr_cnt_q;
    logic [TW-1:0] gamma_time_q;
    logic          op_rst_q;
    logic          busy_q;
    logic          res_valid_q;

    logic          clear_load;
    logic          capture_en;

    // Pulse on the edge that enters CLEAR, so captures reload exactly once.
    always_comb begin
        clear_load = 1'b0;
        if (state_q == IDLE && start) begin
            clear_load = 1'b1;
        end
`ifdef GAMMA_AUTO_RESTART_EN
        if (state_q == HOLD && res_ready) begin
            clear_load = 1'b1;
        end
`endif
    end

    assign capture_en = (state_q == COMPUTE);

    // Sequencer FSM with all status outputs registered alongside the state.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            gamma_time_q <= '0;
            op_rst_q     <= 1'b1;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        op_rst_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q      <= COMPUTE;
                        clr_cnt_q    <= '0;
                        gamma_time_q <= '0;
                        op_rst_q     <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (gamma_time_q == GT_LAST) begin
                        state_q      <= HOLD;
                        gamma_time_q <= '0;
                        res_valid_q  <= 1'b1;
                    end else begin
                        gamma_time_q <= gamma_time_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        op_rst_q    <= 1'b1;
                        clr_cnt_q   <= '0;
`ifdef GAMMA_AUTO_RESTART_EN
                        state_q     <= CLEAR;
`else
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    clr_cnt_q    <= '0;
                    gamma_time_q <= '0;
                    op_rst_q     <= 1'b1;
                    busy_q       <= 1'b0;
                    res_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // One capture slice per observed operator output; channel 0 in the LSBs.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        first_spike_capture #(
            .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
        ) u_cap (
            .aclk    (aclk),
            .grst    (grst),
            .load_i  (clear_load),
            .en_i    (capture_en),
            .spike_i (spike_in[c]),
            .time_i  (gamma_time_q),
            .time_o  (res_time[c*TW +: TW])
        );
    end

    assign op_rst     = op_rst_q;
    assign gamma_time = gamma_time_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// Directed bench for gamma_cycle_sequencer (W=16, 4 channels, 2 clear
// cycles). Each table record is one full gamma cycle: per-channel spike
// waveforms over gamma_time, whether to drive spike noise outside COMPUTE,
// how long to stall res_ready, and the hand-computed res_time.
module tb_gamma_cycle_sequencer;

    localparam int W  = 16;
    localparam int NC = 4;
    localparam int TW = 5;
    localparam logic [19:0] ALL_NO_SPIKE = {5'd16, 5'd16, 5'd16, 5'd16};

    logic          aclk = 1'b0;
    logic          grst;
    logic          start;
    logic [NC-1:0] spike_in;
    logic          op_rst;
    logic [TW-1:0] gamma_time;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [NC*TW-1:0] res_time;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    gamma_cycle_sequencer #(
        .GAMMA_CYCLE_WIDTH(W),
        .NUM_CH(NC),
        .RST_CYCLES(2)
    ) dut (
        .aclk       (aclk),
        .grst       (grst),
        .start      (start),
        .spike_in   (spike_in),
        .op_rst     (op_rst),
        .gamma_time (gamma_time),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_time   (res_time),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 aclk = ~aclk;

    typedef struct {
        string             name;
        logic [3:0][15:0]  wave;          // wave[c][t]: channel c high at gamma_time t
        bit                noise;         // drive all spikes high outside COMPUTE
        int                hold_cycles;   // cycles res_ready stays low in HOLD
        bit                start_in_hold; // pulse start while holding
        logic [19:0]       exp_res;       // {ch3, ch2, ch1, ch0}
    } vec_t;

    vec_t vecs [0:4];

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full gamma cycle from IDLE, checking every cycle's status outputs.
    task automatic run_gamma(input vec_t v);
        int t;
        start    = 1'b1;
        spike_in = v.noise ? 4'hF : 4'h0;
        step();                         // edge k: start sampled
        for (int j = 1; j <= 18; j++) begin
            start = (j == 1);           // busy: must be ignored
            if (j <= 2) begin
                check({v.name, " clear state"}, 32'(dbg_state), 32'd1);
                check({v.name, " clear op_rst"}, 32'(op_rst), 32'd1);
                check({v.name, " clear busy"}, 32'(busy), 32'd1);
                check({v.name, " clear gamma_time"}, 32'(gamma_time), 32'd0);
                check({v.name, " clear res_time"}, 32'(res_time), 32'(ALL_NO_SPIKE));
                spike_in = v.noise ? 4'hF : 4'h0;
            end else begin
                t = j - 3;
                check({v.name, " compute state"}, 32'(dbg_state), 32'd2);
                check({v.name, " compute op_rst"}, 32'(op_rst), 32'd0);
                check({v.name, " compute gamma_time"}, 32'(gamma_time), 32'(t));
                check({v.name, " compute res_valid"}, 32'(res_valid), 32'd0);
                for (int c = 0; c < NC; c++) spike_in[c] = v.wave[c][t];
            end
            step();
        end
        start    = 1'b0;
        spike_in = v.noise ? 4'hF : 4'h0;
        check({v.name, " hold state"}, 32'(dbg_state), 32'd3);
        check({v.name, " hold res_valid"}, 32'(res_valid), 32'd1);
        check({v.name, " hold op_rst"}, 32'(op_rst), 32'd0);
        check({v.name, " hold gamma_time"}, 32'(gamma_time), 32'd0);
        check({v.name, " res_time"}, 32'(res_time), 32'(v.exp_res));
        for (int h = 0; h < v.hold_cycles; h++) begin
            start = v.start_in_hold && (h == 2);
            step();
            check({v.name, " stall res_valid"}, 32'(res_valid), 32'd1);
            check({v.name, " stall res_time"}, 32'(res_time), 32'(v.exp_res));
        end
        start     = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        spike_in  = 4'h0;
        check({v.name, " after ack res_valid"}, 32'(res_valid), 32'd0);
        check({v.name, " after ack op_rst"}, 32'(op_rst), 32'd1);
`ifdef GAMMA_AUTO_RESTART_EN
        check({v.name, " restart state"}, 32'(dbg_state), 32'd1);
        check({v.name, " restart busy"}, 32'(busy), 32'd1);
        check({v.name, " restart res_time"}, 32'(res_time), 32'(ALL_NO_SPIKE));
        grst = 1'b1;
        #2;
        grst = 1'b0;
        step();
`else
        check({v.name, " after ack state"}, 32'(dbg_state), 32'd0);
        check({v.name, " after ack busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check({v.name, " idle stays idle"}, 32'(busy), 32'd0);
        end
`endif
    endtask

    initial begin
        vecs[0] = '{name: "mixed", wave: {16'h8000, 16'h0000, 16'h0001, 16'hFFE0},
                    noise: 1'b0, hold_cycles: 10, start_in_hold: 1'b1,
                    exp_res: {5'd15, 5'd16, 5'd0, 5'd5}};
        vecs[1] = '{name: "simul", wave: {16'h0080, 16'h0080, 16'h0080, 16'h0288},
                    noise: 1'b0, hold_cycles: 0, start_in_hold: 1'b0,
                    exp_res: {5'd7, 5'd7, 5'd7, 5'd3}};
        vecs[2] = '{name: "all_t0", wave: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                    noise: 1'b0, hold_cycles: 1, start_in_hold: 1'b0,
                    exp_res: {5'd0, 5'd0, 5'd0, 5'd0}};
        vecs[3] = '{name: "none_noisy", wave: {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    noise: 1'b1, hold_cycles: 3, start_in_hold: 1'b0,
                    exp_res: {5'd16, 5'd16, 5'd16, 5'd16}};
        vecs[4] = '{name: "singles", wave: {16'h0100, 16'h8000, 16'h0004, 16'h0002},
                    noise: 1'b1, hold_cycles: 2, start_in_hold: 1'b0,
                    exp_res: {5'd8, 5'd15, 5'd2, 5'd1}};

        // Reset
        grst      = 1'b1;
        start     = 1'b0;
        spike_in  = '0;
        res_ready = 1'b0;
        step();
        step();
        check("reset state", 32'(dbg_state), 32'd0);
        check("reset op_rst", 32'(op_rst), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset gamma_time", 32'(gamma_time), 32'd0);
        check("reset res_time", 32'(res_time), 32'(ALL_NO_SPIKE));
        grst = 1'b0;
        step();
        check("idle without start", 32'(busy), 32'd0);

        // Table
        for (int i = 0; i < 5; i++) run_gamma(vecs[i]);

        // Reset mid-COMPUTE at gamma_time 7, after ch0 captured t=3
        start    = 1'b1;
        spike_in = 4'h0;
        step();
        start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            spike_in = (j >= 6) ? 4'h1 : 4'h0;   // ch0 high from t=3
            step();
        end
        check("pre-reset gamma_time", 32'(gamma_time), 32'd7);
        check("pre-reset ch0 captured", 32'(res_time), 32'({5'd16, 5'd16, 5'd16, 5'd3}));
        grst = 1'b1;
        #1;
        check("async reset state", 32'(dbg_state), 32'd0);
        check("async reset op_rst", 32'(op_rst), 32'd1);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset res_valid", 32'(res_valid), 32'd0);
        check("async reset gamma_time", 32'(gamma_time), 32'd0);
        check("async reset res_time", 32'(res_time), 32'(ALL_NO_SPIKE));
        #1;
        grst     = 1'b0;
        spike_in = 4'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("abandoned cycle no result", 32'(res_valid), 32'd0);
        end
        run_gamma(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
